reg_xfer_seq: RTL and testbench
===============================

REG_XFER_SEQ -- requirements
Module: reg_xfer_seq

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the register bank word.
REQ-002 Parameter: AW, default 3, register index width (8 registers).
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 start  input  1  request pulse; sampled only in IDLE.
REQ-007 op  input  2  operation: 00 MOVI, 01 COPY, 10 ADD, 11 SUB.
REQ-008 src_a, src_b  input  AW  source register indices.
REQ-009 dst  input  AW  destination register index.
REQ-010 imm  input  WIDTH  immediate operand for MOVI.
REQ-011 rd_data  input  WIDTH  register bank read data; combinational function of sel.
REQ-012 sel  output  AW  register bank read select.
REQ-013 load_en  output  1  register bank write strobe, one cycle.
REQ-014 load  output  AW  register bank write index.
REQ-015 wr_data  output  WIDTH  register bank write data.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 carry  output  1  ADD carry-out or SUB borrow of the last arithmetic op.

Function
REQ-019 The FSM SHALL have the states IDLE, RDA, RDB, WB and DONE.
REQ-020 In IDLE with start=1, the block SHALL capture op, src_a, src_b, dst and imm into internal registers. Inputs SHALL then be ignored until return to IDLE.
REQ-021 Transitions: IDLE->RDA for COPY/ADD/SUB; IDLE->WB for MOVI; RDA->RDB for ADD/SUB; RDA->WB for COPY; RDB->WB; WB->DONE; DONE->IDLE.
REQ-022 RDA: sel = captured src_a; rd_data latched into opA at the end of the cycle.
REQ-023 RDB: sel = captured src_b; rd_data latched into opB at the end of the cycle.
REQ-024 WB: load_en=1, load=captured dst, wr_data = imm (MOVI), opA (COPY), opA+opB mod 2^WIDTH (ADD), or opA-opB mod 2^WIDTH (SUB).
REQ-025 carry SHALL update only in WB of ADD/SUB: ADD gives the bit-WIDTH carry-out; SUB gives 1 iff opA<opB unsigned. It holds its value otherwise, including through MOVI and COPY.
REQ-026 done=1 only in DONE. Latency from the start-accept edge to done high: MOVI 2, COPY 3, ADD/SUB 4 cycles.
REQ-027 load_en SHALL be 0 in every state except WB. Exactly one write per accepted request.
REQ-028 start asserted while busy=1, or in DONE, SHALL be ignored and SHALL not be queued.
REQ-029 src_a=src_b and dst equal to a source SHALL be legal. The sources are read before WB, so the old value is used.
REQ-030 sel SHALL be 0 in IDLE, WB and DONE. load and wr_data SHALL be 0 outside WB.

Reset
REQ-031 With rst=0 at a rising edge, the block SHALL enter IDLE and clear sel, load_en, load, wr_data, busy, done, carry, opA, opB and all captured fields to 0.
REQ-032 Reset in any state, including WB, SHALL abort the operation. No load_en SHALL be issued after the reset edge.
REQ-033 start is ignored in the cycle rst=0. The first request can be accepted on the first edge with rst=1.

Structure
REQ-034 A shared package SHALL hold the op encodings (OP_MOVI, OP_COPY, OP_ADD, OP_SUB), the FSM state enum, and the WIDTH/AW defaults.
REQ-035 The add/subtract datapath SHALL be one sub-module, xfer_alu: inputs a, b, sub; outputs result[WIDTH-1:0] and carry. The FSM remains in reg_xfer_seq.

Verification
REQ-036 MOVI: start, op=00, imm=8'hA5, dst=3 -> load_en at cycle 1, load=3, wr_data=A5; done at cycle 2; carry unchanged.
REQ-037 ADD overflow: bank r1=8'hF0, r2=8'h20; op=10, src_a=1, src_b=2, dst=4 -> sel=1 at cycle 1, sel=2 at cycle 2, wr_data=8'h10, carry=1 at cycle 3; done at cycle 4.
REQ-038 SUB borrow: r1=8'h05, r2=8'h07; op=11, dst=1 -> wr_data=8'hFE, carry=1. Then r1=8'h07, r2=8'h05 -> wr_data=8'h02, carry=0.
REQ-039 Busy rejection: start ADD, then pulse start with op=00 at cycles 1-3 -> exactly one load_en, and no second done.
REQ-040 Reset in WB: drive rst=0 during the WB cycle of ADD -> next cycle IDLE, all outputs 0, and no load_en on the following cycles.
REQ-041 COPY in place: op=01, src_a=dst=6, r6=8'h3C -> wr_data=8'h3C, load=6; done at cycle 3.

Source files
------------

// File: rtl/reg_xfer_seq_pkg.sv
// Shared definitions for the register-transfer sequencer.
// Holds the operation encodings, the FSM state type and the default
// datapath/index widths used by reg_xfer_seq and xfer_alu.
package reg_xfer_seq_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int AW_DEF    = 3;

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/reg_xfer_seq_alu.sv
// Add/subtract datapath for the register-transfer sequencer.
// Ports:
//   a, b    : operands (WIDTH bits, unsigned)
//   sub     : 0 = a + b, 1 = a - b
//   result  : low WIDTH bits of the sum/difference
//   carry   : add carry-out, or subtract borrow (1 when a < b)
module xfer_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] ext;

  // Extending both operands by one zero bit makes bit WIDTH the carry for
  // addition and the borrow (wrap below zero) for subtraction.
  always_comb begin
    if (sub) ext = {1'b0, a} - {1'b0, b};
    else     ext = {1'b0, a} + {1'b0, b};
  end

  assign result = ext[WIDTH-1:0];
  assign carry  = ext[WIDTH];

endmodule

// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer: accepts one MOVI/COPY/ADD/SUB request at a
// time, reads up to two operands from an external register bank through
// sel/rd_data, then issues exactly one write through load_en/load/wr_data.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   start, op          : request pulse (taken only in IDLE) and operation
//   src_a, src_b, dst  : source/destination register indices
//   imm                : immediate for MOVI
//   rd_data / sel      : bank read data / read select
//   load_en, load,
//   wr_data            : bank write strobe, index, data (WB only)
//   busy, done         : not-idle flag, one-cycle completion pulse
//   carry              : carry/borrow of the last ADD/SUB
module reg_xfer_seq
  import reg_xfer_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] rd_data,
  output logic [AW-1:0]    sel,
  output logic             load_en,
  output logic [AW-1:0]    load,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             carry
);

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic [AW-1:0]    src_a_q, src_b_q, dst_q;
  logic [WIDTH-1:0] imm_q, op_a, op_b;
  logic             carry_q;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  xfer_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .sub    (op_q == OP_SUB),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      carry_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        op_q    <= op;
        src_a_q <= src_a;
        src_b_q <= src_b;
        dst_q   <= dst;
        imm_q   <= imm;
      end
      if (state == S_RDA) op_a <= rd_data;
      if (state == S_RDB) op_b <= rd_data;
      if (state == S_WB && is_arith(op_q)) carry_q <= alu_carry;
    end
  end

  always_comb begin
    state_next = state;
    sel        = '0;
    load_en    = 1'b0;
    load       = '0;
    wr_data    = '0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    carry      = carry_q;
    case (state)
      S_IDLE: begin
        if (start) state_next = (op == OP_MOVI) ? S_WB : S_RDA;
      end
      S_RDA: begin
        sel        = src_a_q;
        state_next = (op_q == OP_COPY) ? S_WB : S_RDB;
      end
      S_RDB: begin
        sel        = src_b_q;
        state_next = S_WB;
      end
      S_WB: begin
        load_en = 1'b1;
        load    = dst_q;
        case (op_q)
          OP_MOVI: wr_data = imm_q;
          OP_COPY: wr_data = op_a;
          default: wr_data = alu_result;
        endcase
        // Present the new carry during the write cycle itself; the register
        // takes it at the end of WB and holds it afterwards.
        if (is_arith(op_q)) carry = alu_carry;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_xfer_seq.sv
module tb_reg_xfer_seq;
  import reg_xfer_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [2:0] src_a, src_b, dst;
  logic [7:0] imm;
  logic [7:0] rd_data;
  logic [2:0] sel;
  logic       load_en;
  logic [2:0] load;
  logic [7:0] wr_data;
  logic       busy, done, carry;

  logic [7:0] bank [8];
  logic       poke_en = 1'b0;
  logic [2:0] poke_idx = '0;
  logic [7:0] poke_val = '0;

  int errors = 0;
  int checks = 0;
  int lc, dc;

  reg_xfer_seq #(.WIDTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .dst(dst), .imm(imm), .rd_data(rd_data), .sel(sel),
    .load_en(load_en), .load(load), .wr_data(wr_data), .busy(busy),
    .done(done), .carry(carry)
  );

  always #5 clk = ~clk;

  assign rd_data = bank[sel];

  always @(posedge clk) begin
    if (load_en) bank[load] <= wr_data;
    if (poke_en) bank[poke_idx] <= poke_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [2:0] idx, input logic [7:0] val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    step();
    poke_en = 1'b0;
  endtask

  // Drive a request for one cycle; returns in cycle 1 after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic [7:0] i);
    op = o; src_a = a; src_b = b; dst = d; imm = i;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) bank[k] = '0;
    rst = 1'b0; start = 1'b0; op = OP_MOVI;
    src_a = '0; src_b = '0; dst = '0; imm = '0;

    // Reset with start held high: request must be ignored.
    poke(3'd1, 8'hF0);
    poke(3'd2, 8'h20);
    start = 1'b1; op = OP_ADD; src_a = 3'd1; src_b = 3'd2; dst = 3'd4;
    step();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_load_en", load_en, 1'b0);
    check("rst_sel", sel, 3'd0);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_carry", carry, 1'b0);
    start = 1'b0;

    // ADD overflow, accepted on the first edge with rst high.
    rst = 1'b1;
    issue(OP_ADD, 3'd1, 3'd2, 3'd4, 8'h00);
    check("add_c1_sel", sel, 3'd1);
    check("add_c1_busy", busy, 1'b1);
    check("add_c1_load_en", load_en, 1'b0);
    step();
    check("add_c2_sel", sel, 3'd2);
    step();
    check("add_c3_load_en", load_en, 1'b1);
    check("add_c3_load", load, 3'd4);
    check("add_c3_wr_data", wr_data, 8'h10);
    check("add_c3_carry", carry, 1'b1);
    check("add_c3_sel", sel, 3'd0);
    step();
    check("add_c4_done", done, 1'b1);
    check("add_c4_load_en", load_en, 1'b0);
    check("add_r4", bank[4], 8'h10);
    step();
    check("add_c5_done", done, 1'b0);
    check("add_c5_busy", busy, 1'b0);
    check("add_c5_carry", carry, 1'b1);

    // MOVI: carry from the ADD must be kept.
    issue(OP_MOVI, 3'd0, 3'd0, 3'd3, 8'hA5);
    check("movi_c1_load_en", load_en, 1'b1);
    check("movi_c1_load", load, 3'd3);
    check("movi_c1_wr_data", wr_data, 8'hA5);
    check("movi_c1_carry", carry, 1'b1);
    step();
    check("movi_c2_done", done, 1'b1);
    check("movi_c2_carry", carry, 1'b1);
    check("movi_r3", bank[3], 8'hA5);
    step();

    // SUB with borrow, destination equal to a source.
    poke(3'd1, 8'h05);
    poke(3'd2, 8'h07);
    issue(OP_SUB, 3'd1, 3'd2, 3'd1, 8'h00);
    step(); step();
    check("sub1_wr_data", wr_data, 8'hFE);
    check("sub1_carry", carry, 1'b1);
    step();
    check("sub1_r1", bank[1], 8'hFE);
    step();

    // SUB without borrow clears carry.
    poke(3'd1, 8'h07);
    poke(3'd2, 8'h05);
    issue(OP_SUB, 3'd1, 3'd2, 3'd1, 8'h00);
    step(); step();
    check("sub2_wr_data", wr_data, 8'h02);
    check("sub2_carry", carry, 1'b0);
    step();
    check("sub2_done", done, 1'b1);
    step();
    check("sub2_hold_carry", carry, 1'b0);

    // Busy rejection: start pulses during cycles 1-3 of an ADD.
    poke(3'd1, 8'hF0);
    poke(3'd2, 8'h20);
    issue(OP_ADD, 3'd1, 3'd2, 3'd5, 8'h00);
    lc = 0; dc = 0;
    for (int i = 1; i <= 8; i++) begin
      start = (i <= 3);
      op = OP_MOVI; dst = 3'd7; imm = 8'h99;
      lc = lc + (load_en ? 1 : 0);
      dc = dc + (done ? 1 : 0);
      step();
    end
    start = 1'b0;
    check("busy_rej_loads", lc, 1);
    check("busy_rej_dones", dc, 1);
    check("busy_rej_r7", bank[7], 8'h00);
    check("busy_rej_r5", bank[5], 8'h10);

    // Reset during WB aborts the operation.
    issue(OP_ADD, 3'd1, 3'd2, 3'd6, 8'h00);
    step(); step();
    check("rstwb_c3_load_en", load_en, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rstwb_busy", busy, 1'b0);
    check("rstwb_done", done, 1'b0);
    check("rstwb_load_en", load_en, 1'b0);
    check("rstwb_load", load, 3'd0);
    check("rstwb_wr_data", wr_data, 8'h00);
    check("rstwb_sel", sel, 3'd0);
    check("rstwb_carry", carry, 1'b0);
    lc = 0; dc = 0;
    for (int i = 0; i < 4; i++) begin
      lc = lc + (load_en ? 1 : 0);
      dc = dc + (done ? 1 : 0);
      step();
    end
    check("rstwb_after_loads", lc, 0);
    check("rstwb_after_dones", dc, 0);

    // COPY in place.
    poke(3'd6, 8'h3C);
    issue(OP_COPY, 3'd6, 3'd0, 3'd6, 8'h00);
    check("copy_c1_sel", sel, 3'd6);
    check("copy_c1_load_en", load_en, 1'b0);
    step();
    check("copy_c2_load_en", load_en, 1'b1);
    check("copy_c2_load", load, 3'd6);
    check("copy_c2_wr_data", wr_data, 8'h3C);
    step();
    check("copy_c3_done", done, 1'b1);
    check("copy_r6", bank[6], 8'h3C);
    step();
    check("copy_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
